// File: rtl/alu_pipe_muldiv_if.sv
// rtl/alu_pipe_muldiv_if.sv - request/result handshake bundle for alu_pipe_muldiv
interface alu_pipe_muldiv_if #(
  parameter int WIDTH = 32
) ();
  localparam int SHW = $clog2(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] data_operandA;
  logic [WIDTH-1:0] data_operandB;
  logic [4:0]       ctrl_ALUopcode;
  logic [SHW-1:0]   ctrl_shiftamt;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] data_result;
  logic             isNotEqual;
  logic             isLessThan;
  logic             overflow;
  logic             busy;

  modport master (
    output in_valid, data_operandA, data_operandB, ctrl_ALUopcode, ctrl_shiftamt, out_ready,
    input  in_ready, out_valid, data_result, isNotEqual, isLessThan, overflow, busy
  );

  modport slave (
    input  in_valid, data_operandA, data_operandB, ctrl_ALUopcode, ctrl_shiftamt, out_ready,
    output in_ready, out_valid, data_result, isNotEqual, isLessThan, overflow, busy
  );
endinterface

// File: rtl/alu_pipe_muldiv.sv
// rtl/alu_pipe_muldiv.sv - handshaked ALU with registered result; iterative signed mul/div when ALU_MULDIV_EN is defined
module alu_pipe_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic               clock,
  input  logic               reset_n,
  alu_pipe_muldiv_if.slave   bus
);
`ifdef ALU_MULDIV_EN
  localparam int SHW = $clog2(WIDTH);
  localparam logic [4:0] OP_MUL = 5'b00110;
  localparam logic [4:0] OP_DIV = 5'b00111;
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;
`else
  typedef enum logic {S_IDLE} state_t;
`endif

  state_t           r_state, w_state_nx;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_result;
  logic             r_ne, r_lt, r_ovf;

  logic             w_in_ready, w_accept, w_start_mul, w_start_div, w_done, w_busy;
  logic [WIDTH-1:0] w_a, w_b, w_sum, w_diff, w_alu_res, w_fin_res;
  logic             w_add_ovf, w_sub_ovf, w_alu_ovf, w_fin_ovf;

  assign w_a        = bus.data_operandA;
  assign w_b        = bus.data_operandB;
  assign w_in_ready = reset_n && (r_state == S_IDLE) && (!r_out_valid || bus.out_ready);
  assign w_accept   = bus.in_valid && w_in_ready;
  assign w_sum      = w_a + w_b;
  assign w_diff     = w_a - w_b;
  assign w_add_ovf  = (w_a[WIDTH-1] == w_b[WIDTH-1]) && (w_sum[WIDTH-1] != w_a[WIDTH-1]);
  assign w_sub_ovf  = (w_a[WIDTH-1] != w_b[WIDTH-1]) && (w_diff[WIDTH-1] != w_a[WIDTH-1]);

  always_comb begin
    w_alu_res = '0;
    w_alu_ovf = 1'b0;
    case (bus.ctrl_ALUopcode)
      5'b00000: begin w_alu_res = w_sum;  w_alu_ovf = w_add_ovf; end
      5'b00001: begin w_alu_res = w_diff; w_alu_ovf = w_sub_ovf; end
      5'b00010: w_alu_res = w_a & w_b;
      5'b00011: w_alu_res = w_a | w_b;
      5'b00100: w_alu_res = w_a << bus.ctrl_shiftamt;
      5'b00101: w_alu_res = $signed(w_a) >>> bus.ctrl_shiftamt;
      default:  w_alu_res = '0;
    endcase
  end

`ifdef ALU_MULDIV_EN
  // r_hi/r_lo form the shared accumulator: product high/low for MUL, remainder/quotient for DIV
  logic [WIDTH-1:0]   r_hi, r_lo, r_mcand;
  logic [SHW-1:0]     r_cnt;
  logic               r_neg, r_bzero, r_dovf;
  logic [WIDTH-1:0]   w_abs_a, w_abs_b, w_hi_nx, w_lo_nx, w_quo;
  logic [WIDTH:0]     w_madd, w_shift, w_trial;
  logic [2*WIDTH-1:0] w_mag, w_prod;

  assign w_start_mul = w_accept && (bus.ctrl_ALUopcode == OP_MUL);
  assign w_start_div = w_accept && (bus.ctrl_ALUopcode == OP_DIV);
  assign w_abs_a     = w_a[WIDTH-1] ? -w_a : w_a;
  assign w_abs_b     = w_b[WIDTH-1] ? -w_b : w_b;
  assign w_done      = (r_state != S_IDLE) && (r_cnt == SHW'(WIDTH-1));
  assign w_busy      = (r_state != S_IDLE);

  always_comb begin
    w_madd  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_mcand} : '0);
    w_shift = {r_hi, r_lo[WIDTH-1]};
    w_trial = w_shift - {1'b0, r_mcand};
    if (r_state == S_DIV) begin
      w_hi_nx = w_trial[WIDTH] ? w_shift[WIDTH-1:0] : w_trial[WIDTH-1:0];
      w_lo_nx = {r_lo[WIDTH-2:0], ~w_trial[WIDTH]};
    end else begin
      w_hi_nx = w_madd[WIDTH:1];
      w_lo_nx = {w_madd[0], r_lo[WIDTH-1:1]};
    end
  end

  // Final result is formed from the last iteration's next values so it lands on edge k+WIDTH
  always_comb begin
    w_mag  = {w_hi_nx, w_lo_nx};
    w_prod = r_neg ? -w_mag : w_mag;
    w_quo  = r_neg ? -w_lo_nx : w_lo_nx;
    if (r_state == S_DIV) begin
      w_fin_res = r_bzero ? '0 : w_quo;
      w_fin_ovf = r_dovf;
    end else begin
      w_fin_res = w_prod[WIDTH-1:0];
      w_fin_ovf = !((&w_prod[2*WIDTH-1:WIDTH-1]) || !(|w_prod[2*WIDTH-1:WIDTH-1]));
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_hi    <= '0;
      r_lo    <= '0;
      r_mcand <= '0;
      r_cnt   <= '0;
      r_neg   <= 1'b0;
      r_bzero <= 1'b0;
      r_dovf  <= 1'b0;
    end else if (w_start_mul || w_start_div) begin
      r_hi    <= '0;
      r_lo    <= w_start_mul ? w_abs_b : w_abs_a;
      r_mcand <= w_start_mul ? w_abs_a : w_abs_b;
      r_cnt   <= '0;
      r_neg   <= w_a[WIDTH-1] ^ w_b[WIDTH-1];
      r_bzero <= (w_b == '0);
      r_dovf  <= (w_b == '0) || ((w_a == {1'b1, {(WIDTH-1){1'b0}}}) && (&w_b));
    end else if (r_state != S_IDLE) begin
      r_hi  <= w_hi_nx;
      r_lo  <= w_lo_nx;
      r_cnt <= r_cnt + SHW'(1);
    end
  end
`else
  assign w_start_mul = 1'b0;
  assign w_start_div = 1'b0;
  assign w_done      = 1'b0;
  assign w_busy      = 1'b0;
  assign w_fin_res   = '0;
  assign w_fin_ovf   = 1'b0;
`endif

  always_comb begin
    w_state_nx = r_state;
`ifdef ALU_MULDIV_EN
    case (r_state)
      S_IDLE: begin
        if (w_start_mul)      w_state_nx = S_MUL;
        else if (w_start_div) w_state_nx = S_DIV;
      end
      S_MUL, S_DIV: if (w_done) w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
`else
    w_state_nx = S_IDLE;
`endif
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nx;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_ne        <= 1'b0;
      r_lt        <= 1'b0;
      r_ovf       <= 1'b0;
    end else if (w_accept) begin
      r_ne <= (w_a != w_b);
      r_lt <= w_diff[WIDTH-1] ^ w_sub_ovf;
      if (w_start_mul || w_start_div) begin
        r_out_valid <= 1'b0;
      end else begin
        r_out_valid <= 1'b1;
        r_result    <= w_alu_res;
        r_ovf       <= w_alu_ovf;
      end
    end else if (w_done) begin
      r_out_valid <= 1'b1;
      r_result    <= w_fin_res;
      r_ovf       <= w_fin_ovf;
    end else if (bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.in_ready    = w_in_ready;
  assign bus.out_valid   = r_out_valid;
  assign bus.data_result = r_result;
  assign bus.isNotEqual  = r_ne;
  assign bus.isLessThan  = r_lt;
  assign bus.overflow    = r_ovf;
  assign bus.busy        = w_busy;
endmodule

// File: doc/alu_pipe_muldiv.md
Name: alu_pipe_muldiv

Overview:
- Parametrised, handshaked successor to the team's 32-bit combinational ALU.
- Keeps the same opcode map and flag semantics: add, sub, and, or, sll, sra, isNotEqual, isLessThan, overflow.
- Adds registered outputs with valid/ready flow control and iterative signed multiply and divide.
- Sits between the decode/regfile stage and writeback in the processor datapath.

Parameters:
- WIDTH, 32, operand/result width in bits; legal values are 8..64, even.
- SHW, $clog2(WIDTH), shift-amount width; derived, not overridden.

Ports:
- clock  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operation request.
- in_ready  out  1  block can accept an operation this cycle.
- data_operandA  in  WIDTH  operand A, two's complement.
- data_operandB  in  WIDTH  operand B, two's complement.
- ctrl_ALUopcode  in  5  operation select.
- ctrl_shiftamt  in  SHW  shift amount for sll/sra.
- out_valid  out  1  result registers hold an unconsumed result.
- out_ready  in  1  consumer accepts the result.
- data_result  out  WIDTH  registered result.
- isNotEqual  out  1  A != B, registered with the result.
- isLessThan  out  1  signed A < B, overflow-corrected, registered with the result.
- overflow  out  1  arithmetic exception, registered with the result.
- busy  out  1  a multiply or divide is iterating.

Behaviour:
- Opcodes:
  - 00000 add; 00001 sub; 00010 and; 00011 or.
  - 00100 sll by ctrl_shiftamt; 00101 sra by ctrl_shiftamt.
  - 00110 mul (low WIDTH bits of the signed product).
  - 00111 div (signed quotient, truncated toward zero).
  - Any other opcode: result 0, overflow 0.
- Reset (asynchronous, reset_n low): state IDLE; out_valid=0; data_result=0; all flags 0; busy=0; in_ready=0 while reset is asserted.
- in_ready = (state==IDLE) && (!out_valid || out_ready).
- Accept: in_valid && in_ready at a rising edge. Opcode, operands and shamt are captured at that edge; later input changes are ignored.
- Flags (every opcode):
  - isNotEqual = (A!=B).
  - isLessThan = sign(A-B) XOR overflow(A-B).
  - Both are computed from the captured operands and delivered with the result.
- Single-cycle ops (add, sub, and, or, sll, sra, illegal): out_valid rises at the accepting edge, i.e. latency 1.
- Overflow for add/sub: signed overflow of the WIDTH-bit operation (carry into MSB XOR carry out). Overflow is 0 for logic and shift ops.
- State machine: IDLE -> MUL or DIV on accepting opcode 00110/00111; iterating state -> IDLE after exactly WIDTH iteration edges.
- Multicycle timing: for an accept at edge k, out_valid rises at edge k+WIDTH. busy=1 from edge k until edge k+WIDTH. in_ready=0 throughout.
- MUL:
  - Radix-2 shift-add on magnitudes; sign applied at completion.
  - overflow=1 iff the exact 2*WIDTH-bit signed product is not representable in WIDTH bits.
- DIV:
  - Restoring division on magnitudes; quotient sign = sign(A) XOR sign(B).
  - B==0: result 0, overflow=1.
  - A==MIN and B==-1: result MIN, overflow=1.
  - The algorithm still runs WIDTH iterations in both exception cases, so latency is fixed.
- Output hold: while out_valid && !out_ready, data_result and the flags are stable.
- Simultaneous consume and accept: if out_valid && out_ready && in_valid && in_ready, the new single-cycle result replaces the old one in the same edge and out_valid stays 1. For mul/div, out_valid drops at that edge.
- out_valid falls on out_ready when no new result is loaded.
- Reset mid-operation: iteration aborted, result discarded, all outputs return to reset values.

Optional Feature:
- Macro: ALU_MULDIV_EN.
- Defined: MUL/DIV states, the iterative datapath and busy exist as specified above.
- Undefined: opcodes 00110/00111 are illegal single-cycle ops (result 0, overflow 0); busy is tied 0; the state machine reduces to IDLE only.

Test Plan:
- Reset release, then sub A=0x00000000, B=0xFFFFFFFF with out_ready=1 -> one cycle later out_valid=1, data_result=0x00000001, isNotEqual=1, isLessThan=0, overflow=0.
- sub A=0x80000001, B=0x7FFFFFFF -> isLessThan=1, overflow=1, data_result=0x00000002. Then add A=B=0x40000000 -> overflow=1, data_result=0x80000000.
- sra A=0x80000000 with shamt 1/2/4/8/16 -> 0xC0000000, 0xE0000000, 0xF8000000, 0xFF800000, 0xFFFF8000. Then sll A=1, shamt 24 -> 0x01000000.
- mul A=-7, B=6 -> exactly 32 cycles after accept, data_result=0xFFFFFFD6, overflow=0; busy=1 and in_ready=0 throughout. Then mul A=B=0x00010000 -> overflow=1.
- div A=-7, B=2 -> 0xFFFFFFFD. div A=5, B=0 -> result 0, overflow=1. div A=0x80000000, B=-1 -> 0x80000000, overflow=1. Each exactly 32 cycles.
- Backpressure: out_ready=0 for 5 cycles after an add result -> data_result held and in_ready=0; releasing out_ready in the same cycle as a new in_valid -> back-to-back results with no bubble. Asserting reset_n=0 mid-div -> out_valid=0 and busy=0 immediately.
